// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream (count, big-endian
// words, XOR checksum) into one memory write per word and holds the CPU in reset until done.
module imem_loader #(
   parameter int          AW   = 6,
   parameter int unsigned MAXW = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          we,
   output logic [AW-1:0] wa,
   output logic [31:0]   wd,
   output logic          done,
   output logic          err,
   output logic          cpu_reset
);

   typedef enum logic [2:0] {
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    count_q, count_d;
   logic [AW:0]   word_idx_q, word_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [7:0]    acc_q, acc_d;
   logic [23:0]   asm_q, asm_d;
   logic          we_q, we_d;
   logic [AW-1:0] wa_q, wa_d;
   logic [31:0]   wd_q, wd_d;
   logic          accept;

   // Ready is gated by reset so it reads low during the reset cycle itself.
   assign in_ready  = !reset && (state_q == S_COUNT || state_q == S_DATA || state_q == S_CHECK);
   assign accept    = in_valid && in_ready;
   assign we        = we_q;
   assign wa        = wa_q;
   assign wd        = wd_q;
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign cpu_reset = !done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_COUNT;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         acc_q      <= '0;
         asm_q      <= '0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         acc_q      <= acc_d;
         asm_q      <= asm_d;
         we_q       <= we_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      acc_d      = acc_q;
      asm_d      = asm_q;
      we_d       = 1'b0;
      wa_d       = wa_q;
      wd_d       = wd_q;
      case (state_q)
         S_COUNT: begin
            if (accept) begin
               count_d = in_data;
               if (in_data == 8'd0 || 32'(in_data) > MAXW) begin
                  state_d = S_ERR;
               end else begin
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  acc_d      = '0;
                  state_d    = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               asm_d      = {asm_q[15:0], in_data};
               acc_d      = acc_q ^ in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  wd_d       = {asm_q, in_data};
                  wa_d       = word_idx_q[AW-1:0];
                  we_d       = 1'b1;
                  word_idx_d = word_idx_q + 1'b1;
                  // Word index is one bit wider than wa so a full 2^AW frame still terminates.
                  if (32'(word_idx_q) + 32'd1 == 32'(count_q)) begin
                     state_d = S_CHECK;
                  end
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (in_data == acc_q) ? S_DONE : S_ERR;
            end
         end
         default: state_d = state_q;
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames push expected writes into a queue and an
// independent monitor pops and compares each write strobe the loader produces.
module tb_imem_loader;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] wa;
   logic [31:0]   wd;
   logic          done;
   logic          err;
   logic          cpu_reset;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [AW+31:0] exp_q[$];
   logic [31:0]    words[64];
   logic           prev_accept = 1'b0;
   bit             spacing_en  = 1'b0;
   bit             have_prev   = 1'b0;
   int             last_wr_cyc = 0;

   imem_loader #(.AW(AW), .MAXW(64)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .we(we),
      .wa(wa),
      .wd(wd),
      .done(done),
      .err(err),
      .cpu_reset(cpu_reset)
   );

   always #5 clk = ~clk;

   // Cycle counter and record of whether a byte was accepted on each edge.
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      prev_accept <= in_valid && in_ready;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_write: got wa=%0d wd=%h required no write", wa, wd);
         end else begin
            logic [AW+31:0] e;
            e = exp_q.pop_front();
            checkOutput("write_wa", 64'(wa), 64'(e[AW+31:32]));
            checkOutput("write_wd", 64'(wd), 64'(e[31:0]));
         end
         checkOutput("write_follows_accept", 64'(prev_accept), 64'd1);
         if (spacing_en) begin
            if (have_prev) checkOutput("write_spacing", 64'(cyc - last_wr_cyc), 64'd4);
            have_prev   = 1'b1;
            last_wr_cyc = cyc;
         end
      end
   end

   // Present one byte after an optional idle gap and wait (bounded) for it to be taken.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      bit taken;
      taken = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 50 && !taken; i++) begin
         if (in_ready) taken = 1'b1;
         @(posedge clk);
         if (!taken) @(negedge clk);
      end
      #1 in_valid = 1'b0;
      if (!taken) begin
         total++;
         bad++;
         $display("[TB] FAIL byte_accept_timeout: got in_ready=0 required 1");
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("ready_in_reset", 64'(in_ready), 64'd0);
      reset = 1'b0;
      #1;
      checkOutput("rst_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_we", 64'(we), 64'd0);
      checkOutput("rst_wa", 64'(wa), 64'd0);
      checkOutput("rst_wd", 64'(wd), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_cpu_reset", 64'(cpu_reset), 64'd1);
   endtask

   // Stream a frame of n words from words[]; stop_after >= 0 aborts after that many data bytes.
   task automatic sendFrame(input int n, input bit flip, input int maxgap, input int stop_after);
      logic [7:0] csum;
      logic [7:0] b;
      int         sent;
      csum = 8'h00;
      sent = 0;
      applyStimulus(8'(n), 0);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (stop_after >= 0 && sent == stop_after) return;
            b    = words[i][31-8*k -: 8];
            csum = csum ^ b;
            if (k == 3) exp_q.push_back({AW'(i), words[i]});
            applyStimulus(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            sent++;
         end
      end
      applyStimulus(csum ^ {7'd0, flip}, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic checkEnd(input string name, input bit exp_done);
      checkOutput({name, "_done"}, 64'(done), 64'(exp_done));
      checkOutput({name, "_err"}, 64'(err), 64'(!exp_done));
      checkOutput({name, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
      checkOutput({name, "_ready"}, 64'(in_ready), 64'd0);
      checkOutput({name, "_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      doReset();

      words[0] = 32'h20080005;
      words[1] = 32'h8C020050;
      sendFrame(2, 1'b0, 0, -1);
      checkEnd("good_n2", 1'b1);
      @(negedge clk);
      checkOutput("done_sticky", 64'(done), 64'd1);

      doReset();
      sendFrame(2, 1'b1, 0, -1);
      checkEnd("bad_csum", 1'b0);

      doReset();
      applyStimulus(8'h00, 0);
      checkEnd("count_zero", 1'b0);

      doReset();
      applyStimulus(8'h41, 0);
      checkEnd("count_too_big", 1'b0);

      doReset();
      for (int i = 0; i < 64; i++) words[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
      spacing_en = 1'b1;
      have_prev  = 1'b0;
      sendFrame(64, 1'b0, 0, -1);
      spacing_en = 1'b0;
      checkEnd("full_n64", 1'b1);

      doReset();
      words[0] = 32'hDEADBEEF;
      words[1] = 32'h0000_0001;
      words[2] = 32'hFF00_A55A;
      sendFrame(3, 1'b0, 5, -1);
      checkEnd("gappy_n3", 1'b1);

      doReset();
      words[0] = 32'h0102_0304;
      words[1] = 32'hCAFE_F00D;
      sendFrame(4, 1'b0, 0, 6);
      repeat (3) @(negedge clk);
      doReset();
      checkOutput("abort_pending", 64'(exp_q.size()), 64'd0);
      words[0] = 32'h1357_2468;
      sendFrame(1, 1'b0, 0, -1);
      checkEnd("after_abort_n1", 1'b1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish required finish");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that fills the instruction memory at boot, the write-side counterpart to the read-only instruction fetch port. It accepts a framed byte stream (word count, big-endian instruction bytes, XOR checksum), assembles 32-bit words, and issues one write per word to the memory's write port at word addresses 0..N-1. The processor is held in reset via `cpu_reset` until a frame completes with a valid checksum.

## Interface
- `AW`, 6: word-address width; memory depth is 2^AW words.
- `MAXW`, 64: maximum accepted word count; must be ≤ 2^AW and ≤ 255.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: byte on `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte; a transfer occurs on an edge with `in_valid && in_ready`.
- `we` out 1: one-cycle write strobe to the instruction memory.
- `wa` out AW: word address for the write.
- `wd` out 32: write data.
- `done` out 1: sticky, frame loaded and checksum matched.
- `err` out 1: sticky, frame rejected.
- `cpu_reset` out 1: holds the processor in reset; equals `!done`.

## Operation
- Frame: byte 0 = word count N; then 4·N data bytes, MSB first per word (same byte order as the hex image); then 1 checksum byte equal to the XOR of all 4·N data bytes. The count byte is excluded from the checksum.
- States: COUNT → DATA → CHECK → DONE; any state may go to ERR as described below. DONE and ERR are terminal until `reset`.
- COUNT: on accept, latch N. If N == 0 or N > MAXW, go to ERR. Otherwise clear the word index, byte index and checksum accumulator, and go to DATA.
- DATA: on each accept, shift the byte into the 32-bit assembly register (`asm <= {asm[23:0], in_data}`), XOR it into the accumulator, and increment the 2-bit byte index.
  - On the 4th byte (index 3): register `wd` = assembled word and `wa` = word index, pulse `we`, increment the word index, and wrap the byte index to 0.
  - After word N-1 is written, go to CHECK.
- CHECK: on accept, compare `in_data` with the accumulator. Equal goes to DONE; unequal goes to ERR.
- DONE: `in_ready` = 0 and `done` = 1. Further `in_valid` is ignored.
- ERR: `in_ready` = 0 and `err` = 1. Words already written stay in memory; the loader never erases them. `cpu_reset` stays 1.
- `in_ready` = 1 in COUNT, DATA and CHECK. It has no combinational dependence on `in_valid`.
- Word index is AW+1 bits wide so N = 2^AW terminates without aliasing. `wa` takes the low AW bits.
- `in_valid` low on any cycle stalls the frame with no state change. There is no timeout.

## Timing
- Reset values: state = COUNT, `in_ready` = 0 during the reset cycle and 1 on the first cycle after, `we` = 0, `wa` = 0, `wd` = 0, `done` = 0, `err` = 0, `cpu_reset` = 1.
- Write latency: `we`, `wa` and `wd` are valid in the cycle after the edge that accepts the 4th byte of a word. `we` is high for exactly 1 cycle. `wa` and `wd` hold until the next write.
- Back-to-back bytes at 1 byte/cycle are sustained, giving at most one write every 4 cycles.
- The last data byte's write and the CHECK state begin together. The checksum byte may be accepted in the very next cycle.
- `done`/`err` rise in the cycle after the checksum (or bad count) byte is accepted. `cpu_reset` falls in that same cycle as `done`.
- `reset` asserted mid-frame: on that edge the state returns to COUNT, all counters and the accumulator clear, `we` is forced to 0 (a pending write is dropped), and `done`/`err` clear.
- `reset` in DONE: `cpu_reset` returns to 1 and a new frame may be loaded.

## Test plan
- N=2, bytes 20 08 00 05 | 8C 02 00 50, checksum = XOR of the eight bytes = 0xFF ^ ... computed by the bench → exactly two `we` pulses: (wa=0, wd=0x20080005), then (wa=1, wd=0x8C020050). `done`=1 and `cpu_reset`=0 one cycle after the checksum byte.
- Same frame with the checksum byte flipped in bit 0 → both writes still occur, then `err`=1, `done`=0, `cpu_reset`=1, `in_ready`=0.
- Count byte 0x00, and separately 0x41 with MAXW=64 → `err`=1 the next cycle with no `we` pulse.
- N=64 streamed at full rate with `in_valid` held high → 64 writes with wa 0..63, each spaced exactly 4 cycles apart; `done` is asserted.
- Random `in_valid` gaps (0-5 cycles) over an N=3 frame → identical `wa`/`wd` sequence to the gap-free run; no write issued during a gap.
- `reset` pulsed after 6 data bytes of an N=4 frame, then a fresh N=1 frame → no write for the aborted 2nd word; the new frame writes wa=0 and asserts `done`.
